// File: rtl/mccu_pkg.sv
// mccu_pkg: shared opcode map, ALU operation codes and FSM state type
// for the multi-cycle control unit and its return stack.
package mccu_pkg;

    // Primary opcodes (top four instruction bits)
    localparam logic [3:0] OPC_MISC  = 4'h0;
    localparam logic [3:0] OPC_ADD   = 4'h1;
    localparam logic [3:0] OPC_SUB   = 4'h2;
    localparam logic [3:0] OPC_MUL   = 4'h3;
    localparam logic [3:0] OPC_AND   = 4'h5;
    localparam logic [3:0] OPC_XOR   = 4'h6;
    localparam logic [3:0] OPC_CMP   = 4'h7;
    localparam logic [3:0] OPC_BR    = 4'h8;
    localparam logic [3:0] OPC_MOVRA = 4'h9;
    localparam logic [3:0] OPC_MOVAR = 4'hA;
    localparam logic [3:0] OPC_JMP   = 4'hB;
    localparam logic [3:0] OPC_CALL  = 4'hC;
    localparam logic [3:0] OPC_RET   = 4'hD;

    // Operand values selecting the accumulator-only operations under OPC_MISC
    localparam int MISC_LS  = 1;
    localparam int MISC_RS  = 2;
    localparam int MISC_CRS = 3;
    localparam int MISC_CLS = 4;
    localparam int MISC_ARS = 5;
    localparam int MISC_INC = 6;
    localparam int MISC_DEC = 7;

    // ALU operation codes driven on alu_op
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_CRS = 4'd7;
    localparam logic [3:0] ALU_CLS = 4'd8;
    localparam logic [3:0] ALU_ASR = 4'd9;
    localparam logic [3:0] ALU_INC = 4'd10;
    localparam logic [3:0] ALU_DEC = 4'd11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MULW  = 2'd2,
        S_HALT  = 2'd3
    } mccu_state_e;

endpackage

// File: rtl/mccu_ret_stack.sv
// mccu_ret_stack: small LIFO of return addresses for CALL/RET.
// Push is ignored when full and pop when empty; the caller flags those.
module mccu_ret_stack #(
    parameter int PC_W      = 8,
    parameter int STK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] top_data_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STK_DEPTH + 1);

    logic [PC_W-1:0]  mem_q [STK_DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign wr_idx     = IDX_W'(count_q);
    assign top_idx    = IDX_W'(count_q - 1'b1);
    assign full_o     = (count_q == CNT_W'(STK_DEPTH));
    assign empty_o    = (count_q == '0);
    assign top_data_o = mem_q[top_idx];

    // Entry storage: only the slot above the current top is ever written
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    // Occupancy counter: reset empties the stack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (push_i && !full_o) begin
            count_q <= count_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle fetch/execute controller owning PC and IR.
// Optional CALL/RET return stack is built when MCCU_CALL_STACK_EN is defined.
module mc_control_unit
    import mccu_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              OPND_W    = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              STK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [OPND_W+3:0] instruction,
    input  logic              cb_reg,
    input  logic              alu_carry,
    input  logic              alu_done,
    output logic              alu_start,
    output logic              reg_read_en,
    output logic [OPND_W-1:0] reg_read_addr,
    output logic              reg_write_en,
    output logic [OPND_W-1:0] reg_write_addr,
    output logic              acc_sel,
    output logic              acc_write_en,
    output logic              acc_output_en,
    output logic [3:0]        alu_op,
    output logic              ext_write_en,
    output logic              cb_write_en,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              stack_err
);

    localparam int IW = OPND_W + 4;

    mccu_state_e       state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc, opnd_pc;
    logic [IW-1:0]     ir_q, ir_d;
    logic [3:0]        opcode;
    logic [OPND_W-1:0] opnd;
    logic              is_halt;
    logic              misc_hit;

    assign opcode    = ir_q[IW-1 -: 4];
    assign opnd      = ir_q[OPND_W-1:0];
    assign is_halt   = &ir_q;
    assign pc_inc    = pc_q + 1'b1;
    assign opnd_pc   = PC_W'(opnd);
    assign imem_req  = reset && (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);

`ifdef MCCU_CALL_STACK_EN
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic            stack_err_q, stack_err_d;
    logic [PC_W-1:0] stk_top;

    mccu_ret_stack #(
        .PC_W      (PC_W),
        .STK_DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (pc_inc),
        .top_data_o  (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    // Sticky stack error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= stack_err_d;
        end
    end

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    // Sequencer: next state, next PC and IR capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
`ifdef MCCU_CALL_STACK_EN
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stack_err_d = stack_err_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instruction;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                if (is_halt) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end else begin
                    case (opcode)
                        OPC_BR:  if (cb_reg) pc_d = opnd_pc;
                        OPC_JMP: pc_d = opnd_pc;
                        OPC_MUL: begin
                            state_d = S_MULW;
                            pc_d    = pc_q;
                        end
`ifdef MCCU_CALL_STACK_EN
                        OPC_CALL: begin
                            if (stk_full) begin
                                stack_err_d = 1'b1;
                                state_d     = S_HALT;
                                pc_d        = pc_q;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = opnd_pc;
                            end
                        end
                        OPC_RET: begin
                            if (stk_empty) begin
                                stack_err_d = 1'b1;
                                state_d     = S_HALT;
                                pc_d        = pc_q;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_top;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_MULW: begin
                if (alu_done) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    // Datapath strobes decoded from state and IR; silent in fetch and halt
    always_comb begin
        alu_start      = 1'b0;
        reg_read_en    = 1'b0;
        reg_read_addr  = '0;
        reg_write_en   = 1'b0;
        reg_write_addr = '0;
        acc_sel        = 1'b0;
        acc_write_en   = 1'b0;
        acc_output_en  = 1'b0;
        alu_op         = ALU_ADD;
        ext_write_en   = 1'b0;
        cb_write_en    = 1'b0;
        misc_hit       = 1'b0;
        if (state_q == S_EXEC && !is_halt) begin
            case (opcode)
                OPC_ADD, OPC_SUB: begin
                    reg_read_en   = 1'b1;
                    reg_read_addr = opnd;
                    alu_op        = (opcode == OPC_SUB) ? ALU_SUB : ALU_ADD;
                    acc_sel       = 1'b1;
                    acc_write_en  = 1'b1;
                    cb_write_en   = 1'b1;
                end
                OPC_AND, OPC_XOR: begin
                    reg_read_en   = 1'b1;
                    reg_read_addr = opnd;
                    alu_op        = (opcode == OPC_XOR) ? ALU_XOR : ALU_AND;
                    acc_sel       = 1'b1;
                    acc_write_en  = 1'b1;
                end
                OPC_CMP: begin
                    reg_read_en   = 1'b1;
                    reg_read_addr = opnd;
                    alu_op        = ALU_SUB;
                    cb_write_en   = 1'b1;
                end
                OPC_MISC: begin
                    misc_hit = 1'b1;
                    case (opnd)
                        OPND_W'(MISC_LS):  alu_op = ALU_SHL;
                        OPND_W'(MISC_RS):  alu_op = ALU_SHR;
                        OPND_W'(MISC_CRS): alu_op = ALU_CRS;
                        OPND_W'(MISC_CLS): alu_op = ALU_CLS;
                        OPND_W'(MISC_ARS): alu_op = ALU_ASR;
                        OPND_W'(MISC_INC): begin
                            alu_op      = ALU_INC;
                            cb_write_en = alu_carry;
                        end
                        OPND_W'(MISC_DEC): begin
                            alu_op      = ALU_DEC;
                            cb_write_en = alu_carry;
                        end
                        default: misc_hit = 1'b0;
                    endcase
                    acc_sel      = misc_hit;
                    acc_write_en = misc_hit;
                end
                OPC_MOVRA: begin
                    reg_read_en   = 1'b1;
                    reg_read_addr = opnd;
                    acc_write_en  = 1'b1;
                end
                OPC_MOVAR: begin
                    acc_output_en  = 1'b1;
                    reg_write_en   = 1'b1;
                    reg_write_addr = opnd;
                end
                OPC_MUL: begin
                    alu_start     = 1'b1;
                    reg_read_en   = 1'b1;
                    reg_read_addr = opnd;
                    alu_op        = ALU_MUL;
                end
                default: ;
            endcase
        end else if (state_q == S_MULW) begin
            reg_read_en   = 1'b1;
            reg_read_addr = opnd;
            alu_op        = ALU_MUL;
            if (alu_done) begin
                acc_sel      = 1'b1;
                acc_write_en = 1'b1;
                ext_write_en = 1'b1;
            end
        end
    end

    // Architectural state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench for mc_control_unit.
// Stimulus pushes expected fetch addresses and strobe patterns; a monitor
// pops and compares whenever the DUT fetches or raises a datapath strobe.
module tb_mc_control_unit;

    localparam int PC_W      = 8;
    localparam int OPND_W    = 4;
    localparam int STK_DEPTH = 2;

    typedef struct {
        string       name;
        logic [19:0] val;
        logic [19:0] mask;
    } strobe_exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       imem_req, imem_ack, cb_reg, alu_carry, alu_done, alu_start;
    logic [7:0] imem_addr, instruction, pc;
    logic       reg_read_en, reg_write_en, acc_sel, acc_write_en, acc_output_en;
    logic [3:0] reg_read_addr, reg_write_addr, alu_op;
    logic       ext_write_en, cb_write_en, halted, stack_err;

    logic [7:0]  mem [256];
    logic        cbMap [256];
    logic        carryMap [256];
    int          fetchCycle [256];
    logic [7:0]  fetchQ [$];
    strobe_exp_t strobeQ [$];

    int   assertCount = 0;
    int   failCount   = 0;
    int   cycleCnt    = 0;
    int   mulCnt      = 0;
    int   mulDelay    = 3;
    logic mulEarly    = 1'b0;
    logic monEn       = 1'b0;

    mc_control_unit #(
        .PC_W      (PC_W),
        .OPND_W    (OPND_W),
        .RESET_PC  (8'h00),
        .STK_DEPTH (STK_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .instruction    (instruction),
        .cb_reg         (cb_reg),
        .alu_carry      (alu_carry),
        .alu_done       (alu_done),
        .alu_start      (alu_start),
        .reg_read_en    (reg_read_en),
        .reg_read_addr  (reg_read_addr),
        .reg_write_en   (reg_write_en),
        .reg_write_addr (reg_write_addr),
        .acc_sel        (acc_sel),
        .acc_write_en   (acc_write_en),
        .acc_output_en  (acc_output_en),
        .alu_op         (alu_op),
        .ext_write_en   (ext_write_en),
        .cb_write_en    (cb_write_en),
        .pc             (pc),
        .halted         (halted),
        .stack_err      (stack_err)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Watchdog so the run always ends
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic noteFail(input string name, input logic [31:0] act);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    function automatic logic [19:0] mkStrobe(input logic st, input logic rd, input logic [3:0] ra,
                                             input logic wr, input logic [3:0] wa, input logic as,
                                             input logic awe, input logic aoe, input logic [3:0] op,
                                             input logic ext, input logic cbw);
        return {st, rd, ra, wr, wa, as, awe, aoe, op, ext, cbw};
    endfunction

    // Queue one expected strobe cycle; unused addresses and (optionally) alu_op are don't-care
    task automatic expectStrobe(input string name, input logic [19:0] val, input logic careOp);
        strobe_exp_t e;
        e.name = name;
        e.val  = val;
        e.mask = 20'hFFFFF;
        if (!careOp) e.mask[5:2] = 4'h0;
        if (!val[18]) e.mask[17:14] = 4'h0;
        if (!val[13]) e.mask[12:9] = 4'h0;
        strobeQ.push_back(e);
    endtask

    function automatic logic [22:0] allOutputs();
        return {imem_req, alu_start, reg_read_en, reg_read_addr, reg_write_en, reg_write_addr,
                acc_sel, acc_write_en, acc_output_en, alu_op, ext_write_en, cb_write_en,
                halted, stack_err};
    endfunction

    // Instruction memory, flag inputs and multiplier model, driven 1ns after each rising edge
    initial begin
        imem_ack = 1'b0; instruction = 8'h00; cb_reg = 1'b0; alu_carry = 1'b0; alu_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack    = imem_req;
            instruction = mem[imem_addr];
            cb_reg      = cbMap[imem_addr];
            alu_carry   = carryMap[imem_addr];
            if (!reset) begin
                mulCnt = 0; alu_done = 1'b0;
            end else if (alu_start) begin
                alu_done = mulEarly; mulCnt = mulDelay;
            end else if (mulCnt > 0) begin
                mulCnt--; alu_done = (mulCnt == 0);
            end else begin
                alu_done = 1'b0;
            end
        end
    end

    // Monitor: compare every fetch handshake and every strobe cycle against the queues
    initial begin
        logic [19:0] vec;
        logic [7:0]  ea;
        strobe_exp_t e;
        forever begin
            @(negedge clk);
            if (reset && monEn) begin
                if (imem_req && imem_ack) begin
                    fetchCycle[imem_addr] = cycleCnt;
                    if (fetchQ.size() == 0) noteFail("fetch_unexpected", 32'(imem_addr));
                    else begin
                        ea = fetchQ.pop_front();
                        checkOutput("fetch_addr", 32'(imem_addr), 32'(ea));
                    end
                end
                vec = {alu_start, reg_read_en, reg_read_addr, reg_write_en, reg_write_addr,
                       acc_sel, acc_write_en, acc_output_en, alu_op, ext_write_en, cb_write_en};
                if (alu_start || reg_read_en || reg_write_en || acc_sel || acc_write_en ||
                    acc_output_en || ext_write_en || cb_write_en || (alu_op != 4'h0)) begin
                    if (strobeQ.size() == 0) noteFail("strobe_unexpected", 32'(vec));
                    else begin
                        e = strobeQ.pop_front();
                        checkOutput(e.name, 32'(vec & e.mask), 32'(e.val & e.mask));
                    end
                end
            end
        end
    end

    // Hold reset, clear queues and fill memory with NOPs
    task automatic startPhase();
        @(posedge clk);
        #3;
        reset = 1'b0;
        monEn = 1'b0;
        fetchQ.delete();
        strobeQ.delete();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h40; cbMap[i] = 1'b0; carryMap[i] = 1'b0; fetchCycle[i] = 0;
        end
        mulEarly = 1'b0;
        mulDelay = 3;
        @(negedge clk);
    endtask

    // Release reset away from the clock edge and start monitoring
    task automatic applyStimulus();
        monEn = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic waitHalted(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(halted), 32'd1);
    endtask

    task automatic checkDrained(input string name);
        checkOutput({name, "_fetchq_left"}, 32'(fetchQ.size()), 32'd0);
        checkOutput({name, "_strobeq_left"}, 32'(strobeQ.size()), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h40; cbMap[i] = 1'b0; carryMap[i] = 1'b0; fetchCycle[i] = 0;
        end

        // Reset state before any stimulus
        @(negedge clk);
        checkOutput("reset_outputs", 32'(allOutputs()), 32'd0);
        checkOutput("reset_pc", 32'(pc), 32'h00);
        checkOutput("reset_imem_addr", 32'(imem_addr), 32'h00);

        // Main program: arithmetic, shifts, INC/DEC carry, branches, MUL, JMP, HALT
        startPhase();
        mem[0]  = 8'h91; mem[1]  = 8'h12; mem[2]  = 8'h85; mem[3]  = 8'h85;
        mem[4]  = 8'hFF; mem[5]  = 8'h26; mem[6]  = 8'h5A; mem[7]  = 8'h73;
        mem[8]  = 8'h01; mem[9]  = 8'h05; mem[10] = 8'h06; mem[11] = 8'h07;
        mem[12] = 8'hA4; mem[13] = 8'h32; mem[15] = 8'hE0; mem[16] = 8'hB4;
`ifdef MCCU_CALL_STACK_EN
        mem[14] = 8'h40;
`else
        mem[14] = 8'hC3;
`endif
        cbMap[2] = 1'b0; cbMap[3] = 1'b1;
        carryMap[10] = 1'b0; carryMap[11] = 1'b1;
        mulEarly = 1'b1;
        foreach (fetchQ[i]) fetchQ.delete(i);
        for (int a = 0; a <= 16; a++) if (a != 4) fetchQ.push_back(8'(a));
        fetchQ.push_back(8'h04);
        expectStrobe("mov_r1_acc", mkStrobe(0,1,4'd1, 0,4'd0, 0,1,0, 4'd0, 0,0), 1'b0);
        expectStrobe("add_r2",     mkStrobe(0,1,4'd2, 0,4'd0, 1,1,0, 4'd0, 0,1), 1'b1);
        expectStrobe("sub_r6",     mkStrobe(0,1,4'd6, 0,4'd0, 1,1,0, 4'd1, 0,1), 1'b1);
        expectStrobe("and_r10",    mkStrobe(0,1,4'd10,0,4'd0, 1,1,0, 4'd0, 0,0), 1'b0);
        expectStrobe("cmp_r3",     mkStrobe(0,1,4'd3, 0,4'd0, 0,0,0, 4'd1, 0,1), 1'b1);
        expectStrobe("shl",        mkStrobe(0,0,4'd0, 0,4'd0, 1,1,0, 4'd5, 0,0), 1'b1);
        expectStrobe("asr",        mkStrobe(0,0,4'd0, 0,4'd0, 1,1,0, 4'd9, 0,0), 1'b1);
        expectStrobe("inc_carry0", mkStrobe(0,0,4'd0, 0,4'd0, 1,1,0, 4'd0, 0,0), 1'b0);
        expectStrobe("dec_carry1", mkStrobe(0,0,4'd0, 0,4'd0, 1,1,0, 4'd0, 0,1), 1'b0);
        expectStrobe("mov_acc_r4", mkStrobe(0,0,4'd0, 1,4'd4, 0,0,1, 4'd0, 0,0), 1'b0);
        expectStrobe("mul_start",  mkStrobe(1,1,4'd2, 0,4'd0, 0,0,0, 4'd2, 0,0), 1'b1);
        expectStrobe("mul_wait1",  mkStrobe(0,1,4'd2, 0,4'd0, 0,0,0, 4'd2, 0,0), 1'b1);
        expectStrobe("mul_wait2",  mkStrobe(0,1,4'd2, 0,4'd0, 0,0,0, 4'd2, 0,0), 1'b1);
        expectStrobe("mul_done",   mkStrobe(0,1,4'd2, 0,4'd0, 1,1,0, 4'd2, 1,0), 1'b1);
        applyStimulus();
        waitHalted("prog_halted", 300);
        checkOutput("two_instr_cycles", 32'(fetchCycle[2] - fetchCycle[0]), 32'd4);
        checkOutput("mul_instr_cycles", 32'(fetchCycle[14] - fetchCycle[13]), 32'd5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("halt_pc_hold", 32'(pc), 32'h04);
            checkOutput("halt_req_low", 32'(imem_req), 32'd0);
            checkOutput("halt_flag", 32'(halted), 32'd1);
        end
`ifndef MCCU_CALL_STACK_EN
        checkOutput("no_stack_err", 32'(stack_err), 32'd0);
`endif
        checkDrained("prog");

        // PC wrap from 0xFF to 0x00 through a run of NOPs
        startPhase();
        for (int a = 0; a < 256; a++) fetchQ.push_back(8'(a));
        fetchQ.push_back(8'h00);
        fetchQ.push_back(8'h01);
        applyStimulus();
        n = 0;
        while (imem_addr != 8'hFF && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_pc_ff", 32'(imem_addr), 32'hFF);
        mem[1] = 8'hFF;
        waitHalted("wrap_halted", 100);
        checkOutput("wrap_pc", 32'(pc), 32'h01);
        checkDrained("wrap");

        // Asynchronous reset while waiting on the multiplier
        startPhase();
        mem[0] = 8'h32;
        mulDelay = 0;
        applyStimulus();
        monEn = 1'b0;
        n = 0;
        while (!alu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mul_started", 32'(alu_start), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mulw_read_en", 32'(reg_read_en), 32'd1);
        checkOutput("mulw_alu_op", 32'(alu_op), 32'd2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_mul_outputs", 32'(allOutputs()), 32'd0);
        checkOutput("rst_mid_mul_pc", 32'(pc), 32'h00);
        checkOutput("rst_mid_mul_addr", 32'(imem_addr), 32'h00);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("release_imem_req", 32'(imem_req), 32'd1);
        checkOutput("release_imem_addr", 32'(imem_addr), 32'h00);

`ifdef MCCU_CALL_STACK_EN
        // Balanced CALL/RET returns to the instruction after the call
        startPhase();
        mem[0] = 8'hC4; mem[4] = 8'hD0; mem[1] = 8'hFF;
        fetchQ.push_back(8'h00); fetchQ.push_back(8'h04); fetchQ.push_back(8'h01);
        applyStimulus();
        waitHalted("callret_halted", 50);
        checkOutput("callret_pc", 32'(pc), 32'h01);
        checkOutput("callret_no_err", 32'(stack_err), 32'd0);
        checkDrained("callret");

        // Third CALL overflows a two-entry stack
        startPhase();
        mem[0] = 8'hC3; mem[3] = 8'hC5; mem[5] = 8'hC7;
        fetchQ.push_back(8'h00); fetchQ.push_back(8'h03); fetchQ.push_back(8'h05);
        applyStimulus();
        waitHalted("overflow_halted", 50);
        checkOutput("overflow_err", 32'(stack_err), 32'd1);
        checkOutput("overflow_pc", 32'(pc), 32'h05);
        checkDrained("overflow");

        // RET on an empty stack
        startPhase();
        mem[0] = 8'hD0;
        fetchQ.push_back(8'h00);
        applyStimulus();
        waitHalted("underflow_halted", 50);
        checkOutput("underflow_err", 32'(stack_err), 32'd1);
        checkOutput("underflow_pc", 32'(pc), 32'h00);
        checkDrained("underflow");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
